// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the multi-cycle divider.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic RST_ENABLE          = 1'b1;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_ctrl.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up at
// the end, result held until EX drops start_i.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  div_state_e            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  // {partial remainder, dividend/quotient bits, shift-in bit}
  logic [2*DATA_W:0]     dividend, dividend_nxt;
  logic [DATA_W-1:0]     divisor, divisor_nxt;
  logic                  sdiv, sdiv_nxt;
  logic                  sign1, sign1_nxt;
  logic                  sign2, sign2_nxt;
  logic [2*DATA_W-1:0]   res, res_nxt;
  logic [2*DATA_W-1:0]   result_nxt;
  logic                  ready_nxt, busy_nxt;

  logic [DATA_W-1:0]     abs1, abs2, quot, rem;
  logic [DATA_W:0]       diff;

  // Operand magnitudes, trial subtraction and final sign correction.
  always_comb begin
    abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    diff = dividend[2*DATA_W:DATA_W] - {1'b0, divisor};
    quot = dividend[DATA_W-1:0];
    rem  = dividend[2*DATA_W:DATA_W+1];
    if (sdiv && (sign1 ^ sign2)) quot = -dividend[DATA_W-1:0];
    if (sdiv && sign1)           rem  = -dividend[2*DATA_W:DATA_W+1];
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    sdiv_nxt     = sdiv;
    sign1_nxt    = sign1;
    sign2_nxt    = sign2;
    res_nxt      = res;
    ready_nxt    = DIV_RESULT_NOT_READY;
    result_nxt   = '0;
    unique case (state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          sdiv_nxt    = signed_div_i;
          sign1_nxt   = opdata1_i[DATA_W-1];
          sign2_nxt   = opdata2_i[DATA_W-1];
          divisor_nxt = abs2;
          if (opdata2_i == '0) begin
            state_nxt = DIV_BYZERO;
          end else begin
            state_nxt    = DIV_ON;
            cnt_nxt      = '0;
            dividend_nxt = {{DATA_W{1'b0}}, abs1, 1'b0};
          end
        end
      end
      DIV_BYZERO: begin
        res_nxt   = '0;
        state_nxt = DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_nxt = DIV_FREE;
        end else if (cnt != LAST_CNT) begin
          // Borrow means divisor did not fit: shift in a 0 and keep remainder.
          if (diff[DATA_W]) dividend_nxt = dividend << 1;
          else dividend_nxt = {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
          cnt_nxt = cnt + 1'b1;
        end else begin
          res_nxt   = {rem, quot};
          state_nxt = DIV_END;
        end
      end
      DIV_END: begin
        if (start_i == DIV_START) begin
          ready_nxt  = DIV_RESULT_READY;
          result_nxt = res;
        end else begin
          state_nxt = DIV_FREE;
        end
      end
      default: state_nxt = DIV_FREE;
    endcase
    busy_nxt = (state_nxt == DIV_BYZERO) || (state_nxt == DIV_ON);
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      sdiv     <= 1'b0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      res      <= '0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dividend <= dividend_nxt;
      divisor  <= divisor_nxt;
      sdiv     <= sdiv_nxt;
      sign1    <= sign1_nxt;
      sign2    <= sign2_nxt;
      res      <= res_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
      busy_o   <= busy_nxt;
    end
  end

endmodule
